// File: rtl/rv32_sram_arbiter.sv
// Shares one single-port SRAM between ifetch, data and DMA ports; dm > if > dma with a DMA starvation guard.
// Grant is combinational, read data returns one cycle later; losers hold their request. Counters need RV32_ARB_STATS_EN.
module rv32_sram_arbiter #(
    parameter int DEPTH      = 1024,
    parameter int STARVE_MAX = 8,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          if_req,
    input  logic          dm_req,
    input  logic          dma_req,
    input  logic [31:0]   if_addr,
    input  logic [31:0]   dm_addr,
    input  logic [31:0]   dma_addr,
    input  logic          dm_we,
    input  logic          dma_we,
    input  logic [3:0]    dm_be,
    input  logic [31:0]   dm_wdata,
    input  logic [31:0]   dma_wdata,
    output logic          if_gnt,
    output logic          dm_gnt,
    output logic          dma_grant,
    output logic          if_rvalid,
    output logic          dm_rvalid,
    output logic          dma_rvalid,
    output logic [31:0]   if_rdata,
    output logic [31:0]   dm_rdata,
    output logic [31:0]   dma_rdata,
    output logic          dm_err,
    output logic          dma_err,
    output logic          sram_en,
    output logic          sram_we,
    output logic [3:0]    sram_be,
    output logic [AW-1:0] sram_addr,
    output logic [31:0]   sram_wdata,
    input  logic [31:0]   sram_rdata,
    output logic [31:0]   stat_if,
    output logic [31:0]   stat_dm,
    output logic [31:0]   stat_dma,
    output logic [31:0]   stat_conflict
);
    typedef enum logic [1:0] {PORT_NONE, PORT_IF, PORT_DM, PORT_DMA} port_e;

    port_e       sel;
    logic [31:0] sel_addr;
    logic        sel_we;
    logic [3:0]  sel_be;
    logic [31:0] sel_wdata;
    logic        sel_oor;
    logic        starve_hit;
    logic [7:0]  starve_q, starve_d;
    port_e       tag_port_q, tag_port_d;
    logic        tag_rd_q, tag_rd_d;
    logic        tag_oor_q, tag_oor_d;
    logic        unused_addr_lsb;

    assign starve_hit = dma_req && (starve_q == 8'(STARVE_MAX));

    always_comb begin
        sel = PORT_NONE;
        if (rst_n) begin
            if (starve_hit)   sel = PORT_DMA;
            else if (dm_req)  sel = PORT_DM;
            else if (if_req)  sel = PORT_IF;
            else if (dma_req) sel = PORT_DMA;
        end
    end

    assign if_gnt    = (sel == PORT_IF);
    assign dm_gnt    = (sel == PORT_DM);
    assign dma_grant = (sel == PORT_DMA);

    always_comb begin
        sel_addr  = 32'h0;
        sel_we    = 1'b0;
        sel_be    = 4'h0;
        sel_wdata = 32'h0;
        case (sel)
            PORT_IF: begin
                sel_addr = if_addr;
                sel_be   = 4'hF;
            end
            PORT_DM: begin
                sel_addr  = dm_addr;
                sel_we    = dm_we;
                sel_be    = dm_be;
                sel_wdata = dm_wdata;
            end
            PORT_DMA: begin
                sel_addr  = dma_addr;
                sel_we    = dma_we;
                sel_be    = 4'hF;
                sel_wdata = dma_wdata;
            end
            default: ;
        endcase
    end

    // Out-of-range requests are still granted so the requester can retire them, but never reach the macro.
    assign sel_oor         = ({2'b00, sel_addr[31:2]} >= 32'(DEPTH));
    assign sram_en         = (sel != PORT_NONE) && !sel_oor;
    assign sram_we         = sram_en && sel_we;
    assign sram_be         = sel_be;
    assign sram_addr       = sel_addr[AW+1:2];
    assign sram_wdata      = sel_wdata;
    assign unused_addr_lsb = ^sel_addr[1:0];

    always_comb begin
        starve_d = starve_q;
        if (!dma_req || dma_grant) starve_d = 8'h0;
        else if (starve_q != 8'hFF) starve_d = starve_q + 8'h1;
        tag_port_d = sel;
        tag_rd_d   = !sel_we;
        tag_oor_d  = sel_oor;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            starve_q   <= 8'h0;
            tag_port_q <= PORT_NONE;
            tag_rd_q   <= 1'b0;
            tag_oor_q  <= 1'b0;
        end else begin
            starve_q   <= starve_d;
            tag_port_q <= tag_port_d;
            tag_rd_q   <= tag_rd_d;
            tag_oor_q  <= tag_oor_d;
        end
    end

    assign if_rvalid  = (tag_port_q == PORT_IF) && tag_rd_q;
    assign dm_rvalid  = (tag_port_q == PORT_DM) && tag_rd_q;
    assign dma_rvalid = (tag_port_q == PORT_DMA) && tag_rd_q;
    assign if_rdata   = (if_rvalid && !tag_oor_q) ? sram_rdata : 32'h0;
    assign dm_rdata   = (dm_rvalid && !tag_oor_q) ? sram_rdata : 32'h0;
    assign dma_rdata  = (dma_rvalid && !tag_oor_q) ? sram_rdata : 32'h0;
    assign dm_err     = (tag_port_q == PORT_DM) && tag_oor_q;
    assign dma_err    = (tag_port_q == PORT_DMA) && tag_oor_q;

`ifdef RV32_ARB_STATS_EN
    logic [31:0] stat_if_q, stat_dm_q, stat_dma_q, stat_conflict_q;
    logic        req_conflict;

    assign req_conflict = (if_req && dm_req) || (if_req && dma_req) || (dm_req && dma_req);

    // All counters saturate rather than wrap.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_if_q       <= 32'h0;
            stat_dm_q       <= 32'h0;
            stat_dma_q      <= 32'h0;
            stat_conflict_q <= 32'h0;
        end else begin
            if (if_gnt && stat_if_q != 32'hFFFF_FFFF) stat_if_q <= stat_if_q + 32'h1;
            if (dm_gnt && stat_dm_q != 32'hFFFF_FFFF) stat_dm_q <= stat_dm_q + 32'h1;
            if (dma_grant && stat_dma_q != 32'hFFFF_FFFF) stat_dma_q <= stat_dma_q + 32'h1;
            if (req_conflict && stat_conflict_q != 32'hFFFF_FFFF)
                stat_conflict_q <= stat_conflict_q + 32'h1;
        end
    end

    assign stat_if       = stat_if_q;
    assign stat_dm       = stat_dm_q;
    assign stat_dma      = stat_dma_q;
    assign stat_conflict = stat_conflict_q;
`else
    assign stat_if       = 32'h0;
    assign stat_dm       = 32'h0;
    assign stat_dma      = 32'h0;
    assign stat_conflict = 32'h0;
`endif

endmodule

// File: tb/tb_rv32_sram_arbiter.sv
// Directed bench for rv32_sram_arbiter with a behavioural single-port SRAM behind it.
module tb_rv32_sram_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req, dm_req, dma_req;
    logic [31:0] if_addr, dm_addr, dma_addr;
    logic        dm_we, dma_we;
    logic [3:0]  dm_be;
    logic [31:0] dm_wdata, dma_wdata;
    logic        if_gnt, dm_gnt, dma_grant;
    logic        if_rvalid, dm_rvalid, dma_rvalid;
    logic [31:0] if_rdata, dm_rdata, dma_rdata;
    logic        dm_err, dma_err;
    logic        sram_en, sram_we;
    logic [3:0]  sram_be;
    logic [9:0]  sram_addr;
    logic [31:0] sram_wdata, sram_rdata;
    logic [31:0] stat_if, stat_dm, stat_dma, stat_conflict;

    logic [31:0] mem [0:1023];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rv32_sram_arbiter #(.DEPTH(1024), .STARVE_MAX(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .dm_req(dm_req), .dma_req(dma_req),
        .if_addr(if_addr), .dm_addr(dm_addr), .dma_addr(dma_addr),
        .dm_we(dm_we), .dma_we(dma_we), .dm_be(dm_be),
        .dm_wdata(dm_wdata), .dma_wdata(dma_wdata),
        .if_gnt(if_gnt), .dm_gnt(dm_gnt), .dma_grant(dma_grant),
        .if_rvalid(if_rvalid), .dm_rvalid(dm_rvalid), .dma_rvalid(dma_rvalid),
        .if_rdata(if_rdata), .dm_rdata(dm_rdata), .dma_rdata(dma_rdata),
        .dm_err(dm_err), .dma_err(dma_err),
        .sram_en(sram_en), .sram_we(sram_we), .sram_be(sram_be),
        .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
        .stat_if(stat_if), .stat_dm(stat_dm), .stat_dma(stat_dma),
        .stat_conflict(stat_conflict)
    );

    always @(posedge clk) begin
        if (sram_en) begin
            if (sram_we) begin
                if (sram_be[0]) mem[sram_addr][7:0]   <= sram_wdata[7:0];
                if (sram_be[1]) mem[sram_addr][15:8]  <= sram_wdata[15:8];
                if (sram_be[2]) mem[sram_addr][23:16] <= sram_wdata[23:16];
                if (sram_be[3]) mem[sram_addr][31:24] <= sram_wdata[31:24];
            end else begin
                sram_rdata <= mem[sram_addr];
            end
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; if_req = 1'b1; dm_req = 1'b1; dma_req = 1'b1;
        for (int i = 0; i < 2; i++) begin
            cycle();
            checks++; if ({if_gnt, dm_gnt, dma_grant} !== 3'b000) begin errors++; $display("FAIL rst_gnt got %b exp 000", {if_gnt, dm_gnt, dma_grant}); end
            checks++; if (sram_en !== 1'b0) begin errors++; $display("FAIL rst_sram_en got %b exp 0", sram_en); end
            checks++; if ({if_rvalid, dm_rvalid, dma_rvalid, dm_err, dma_err} !== 5'b0) begin errors++; $display("FAIL rst_rvalid_err got %b exp 00000", {if_rvalid, dm_rvalid, dma_rvalid, dm_err, dma_err}); end
            checks++; if ({stat_if, stat_dm, stat_dma, stat_conflict} !== 128'h0) begin errors++; $display("FAIL rst_stats got %h exp 0", {stat_if, stat_dm, stat_dma, stat_conflict}); end
        end
        rst_n = 1'b1; if_req = 1'b0; dm_req = 1'b0; dma_req = 1'b0;
        cycle();
        checks++; if ({if_rvalid, dm_rvalid, dma_rvalid} !== 3'b000) begin errors++; $display("FAIL rst_midread_rvalid got %b exp 000", {if_rvalid, dm_rvalid, dma_rvalid}); end
    endtask

    task automatic test_write_path();
        logic [31:0] wa [3];
        logic [31:0] wd [3];
        logic [9:0]  wi [3];
        wa[0] = 32'h0000_0400; wd[0] = 32'h0000_000F; wi[0] = 10'd256;
        wa[1] = 32'h0000_0000; wd[1] = 32'h1234_5678; wi[1] = 10'd0;
        wa[2] = 32'h0000_0008; wd[2] = 32'hCAFE_0002; wi[2] = 10'd2;
        for (int i = 0; i < 3; i++) begin
            dma_req = 1'b1; dma_we = 1'b1; dma_addr = wa[i]; dma_wdata = wd[i];
            #1;
            checks++; if ({dma_grant, sram_en, sram_we, sram_be} !== 7'b111_1111) begin errors++; $display("FAIL wr_ctrl[%0d] got %b exp 1111111", i, {dma_grant, sram_en, sram_we, sram_be}); end
            checks++; if (sram_addr !== wi[i]) begin errors++; $display("FAIL wr_addr[%0d] got %0d exp %0d", i, sram_addr, wi[i]); end
            cycle();
            dma_req = 1'b0; dma_we = 1'b0;
            checks++; if ({dma_rvalid, dma_err} !== 2'b00) begin errors++; $display("FAIL wr_no_rvalid[%0d] got %b exp 00", i, {dma_rvalid, dma_err}); end
            checks++; if (mem[wi[i]] !== wd[i]) begin errors++; $display("FAIL wr_mem[%0d] got %h exp %h", i, mem[wi[i]], wd[i]); end
        end
    endtask

    task automatic test_single_read();
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h0000_0400;
        #1;
        checks++; if ({if_gnt, dm_gnt, dma_grant} !== 3'b010) begin errors++; $display("FAIL rd_gnt got %b exp 010", {if_gnt, dm_gnt, dma_grant}); end
        checks++; if ({sram_en, sram_we, sram_addr} !== {2'b10, 10'd256}) begin errors++; $display("FAIL rd_sram got %b exp 10_0100000000", {sram_en, sram_we, sram_addr}); end
        cycle();
        dm_req = 1'b0;
        checks++; if ({dm_rvalid, dm_rdata} !== {1'b1, 32'h0000_000F}) begin errors++; $display("FAIL rd_data got %b/%h exp 1/0000000f", dm_rvalid, dm_rdata); end
        checks++; if ({if_rvalid, dma_rvalid, dm_err} !== 3'b000) begin errors++; $display("FAIL rd_others got %b exp 000", {if_rvalid, dma_rvalid, dm_err}); end
        cycle();
        checks++; if ({dm_rvalid, dm_rdata} !== 33'h0) begin errors++; $display("FAIL rd_idle got %b/%h exp 0/00000000", dm_rvalid, dm_rdata); end
    endtask

    task automatic test_priority();
        logic [31:0] exp_conf, exp_one;
`ifdef RV32_ARB_STATS_EN
        exp_conf = 32'd2; exp_one = 32'd1;
`else
        exp_conf = 32'd0; exp_one = 32'd0;
`endif
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        if_req = 1'b1; if_addr = 32'h0;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h400;
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h8;
        #1;
        checks++; if ({if_gnt, dm_gnt, dma_grant} !== 3'b010) begin errors++; $display("FAIL pri_c1 got %b exp 010", {if_gnt, dm_gnt, dma_grant}); end
        cycle();
        dm_req = 1'b0;
        #1;
        checks++; if ({if_gnt, dm_gnt, dma_grant} !== 3'b100) begin errors++; $display("FAIL pri_c2 got %b exp 100", {if_gnt, dm_gnt, dma_grant}); end
        checks++; if ({dm_rvalid, dm_rdata} !== {1'b1, 32'h0000_000F}) begin errors++; $display("FAIL pri_dm_data got %b/%h exp 1/0000000f", dm_rvalid, dm_rdata); end
        cycle();
        if_req = 1'b0;
        #1;
        checks++; if ({if_gnt, dm_gnt, dma_grant} !== 3'b001) begin errors++; $display("FAIL pri_c3 got %b exp 001", {if_gnt, dm_gnt, dma_grant}); end
        checks++; if ({if_rvalid, if_rdata} !== {1'b1, 32'h1234_5678}) begin errors++; $display("FAIL pri_if_data got %b/%h exp 1/12345678", if_rvalid, if_rdata); end
        cycle();
        dma_req = 1'b0;
        checks++; if ({dma_rvalid, dma_rdata} !== {1'b1, 32'hCAFE_0002}) begin errors++; $display("FAIL pri_dma_data got %b/%h exp 1/cafe0002", dma_rvalid, dma_rdata); end
        checks++; if (stat_conflict !== exp_conf) begin errors++; $display("FAIL pri_stat_conflict got %0d exp %0d", stat_conflict, exp_conf); end
        checks++; if ({stat_if, stat_dm, stat_dma} !== {exp_one, exp_one, exp_one}) begin errors++; $display("FAIL pri_stat_grants got %0d/%0d/%0d exp %0d each", stat_if, stat_dm, stat_dma, exp_one); end
    endtask

    task automatic test_starvation();
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h400;
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h8;
        for (int i = 1; i <= 8; i++) begin
            #1;
            checks++; if ({dm_gnt, dma_grant} !== 2'b10) begin errors++; $display("FAIL starve_wait[%0d] got %b exp 10", i, {dm_gnt, dma_grant}); end
            cycle();
        end
        #1;
        checks++; if ({dm_gnt, dma_grant} !== 2'b01) begin errors++; $display("FAIL starve_force got %b exp 01", {dm_gnt, dma_grant}); end
        cycle();
        #1;
        checks++; if ({dm_gnt, dma_grant} !== 2'b10) begin errors++; $display("FAIL starve_regain got %b exp 10", {dm_gnt, dma_grant}); end
        checks++; if ({dma_rvalid, dma_rdata} !== {1'b1, 32'hCAFE_0002}) begin errors++; $display("FAIL starve_dma_data got %b/%h exp 1/cafe0002", dma_rvalid, dma_rdata); end
        cycle();
        dm_req = 1'b0; dma_req = 1'b0;
        cycle();
    endtask

    task automatic test_out_of_range();
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h0000_1000; dma_wdata = 32'hDEAD_BEEF;
        #1;
        checks++; if ({dma_grant, sram_en} !== 2'b10) begin errors++; $display("FAIL oor_dma_c got %b exp 10", {dma_grant, sram_en}); end
        cycle();
        dma_req = 1'b0; dma_we = 1'b0;
        checks++; if ({dma_err, dma_rvalid} !== 2'b10) begin errors++; $display("FAIL oor_dma_err got %b exp 10", {dma_err, dma_rvalid}); end
        checks++; if (mem[0] !== 32'h1234_5678) begin errors++; $display("FAIL oor_mem got %h exp 12345678", mem[0]); end
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'hFFFF_FFF0;
        #1;
        checks++; if ({dm_gnt, sram_en} !== 2'b10) begin errors++; $display("FAIL oor_dm_c got %b exp 10", {dm_gnt, sram_en}); end
        cycle();
        dm_req = 1'b0;
        checks++; if ({dm_err, dm_rvalid, dm_rdata} !== {2'b11, 32'h0}) begin errors++; $display("FAIL oor_dm_resp got %b/%b/%h exp 1/1/00000000", dm_err, dm_rvalid, dm_rdata); end
        if_req = 1'b1; if_addr = 32'h0000_1000;
        cycle();
        if_req = 1'b0;
        checks++; if ({if_rvalid, if_rdata, dm_err, dma_err} !== {1'b1, 32'h0, 2'b00}) begin errors++; $display("FAIL oor_if_resp got %b/%h/%b%b exp 1/00000000/00", if_rvalid, if_rdata, dm_err, dma_err); end
    endtask

    task automatic test_byte_write();
        dm_req = 1'b1; dm_we = 1'b1; dm_be = 4'b0010; dm_addr = 32'h400; dm_wdata = 32'hAABB_CCDD;
        #1;
        checks++; if ({dm_gnt, sram_en, sram_we, sram_be} !== 7'b111_0010) begin errors++; $display("FAIL bw_ctrl got %b exp 1110010", {dm_gnt, sram_en, sram_we, sram_be}); end
        cycle();
        dm_we = 1'b0; dm_be = 4'hF;
        checks++; if ({dm_rvalid, dm_err} !== 2'b00) begin errors++; $display("FAIL bw_no_rvalid got %b exp 00", {dm_rvalid, dm_err}); end
        cycle();
        dm_req = 1'b0;
        checks++; if ({dm_rvalid, dm_rdata} !== {1'b1, 32'h0000_CC0F}) begin errors++; $display("FAIL bw_readback got %b/%h exp 1/0000cc0f", dm_rvalid, dm_rdata); end
    endtask

    initial begin
        rst_n = 1'b0;
        if_req = 1'b0; dm_req = 1'b0; dma_req = 1'b0;
        if_addr = 32'h0; dm_addr = 32'h400; dma_addr = 32'h0;
        dm_we = 1'b0; dma_we = 1'b0; dm_be = 4'hF;
        dm_wdata = 32'h0; dma_wdata = 32'h0;
        test_reset();
        test_write_path();
        test_single_read();
        test_priority();
        test_starvation();
        test_out_of_range();
        test_byte_write();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
